// File: rtl/pc_fetch_ctrl_rv32i.sv
// pc_fetch_ctrl_rv32i: RV32I instruction-fetch controller that sequences the PC through a req/gnt/rvalid
// memory handshake and supports redirects, which flush any response still in flight.
module pc_fetch_ctrl_rv32i #(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        misalign_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_instr_pc, w_instr_pc_nxt;
   logic        r_flush, w_flush_nxt;
   logic        r_misalign;
   logic        w_redir;
   logic        w_bad_redir;

   assign w_redir     = redirect_valid && (redirect_target[1:0] == 2'b00);
   assign w_bad_redir = redirect_valid && (redirect_target[1:0] != 2'b00);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_state    <= IDLE;
         r_pc       <= RESET_VECTOR;
         r_instr    <= 32'h0;
         r_instr_pc <= 32'h0;
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_instr_pc <= w_instr_pc_nxt;
         r_flush    <= w_flush_nxt;
         r_misalign <= w_bad_redir;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_instr_pc_nxt = r_instr_pc;
      w_flush_nxt    = r_flush;
      case (r_state)
         IDLE: begin
            w_state_nxt = REQ;
            w_pc_nxt    = w_redir ? redirect_target : r_pc;
         end
         REQ: begin
            w_state_nxt = imem_gnt ? WAIT : REQ;
            if (w_redir) begin
               // a grant accepted alongside a redirect returns stale data; mark it for discard
               w_pc_nxt    = redirect_target;
               w_flush_nxt = imem_gnt;
            end
         end
         WAIT: begin
            if (w_redir) begin
               w_pc_nxt    = redirect_target;
               w_flush_nxt = !imem_rvalid;
               w_state_nxt = imem_rvalid ? REQ : WAIT;
            end else if (imem_rvalid && r_flush) begin
               w_flush_nxt = 1'b0;
               w_state_nxt = REQ;
            end else if (imem_rvalid) begin
               w_instr_nxt    = imem_rdata;
               w_instr_pc_nxt = r_pc;
               w_pc_nxt       = r_pc + 32'd4;
               w_state_nxt    = VALID;
            end
         end
         VALID: begin
            w_pc_nxt    = w_redir ? redirect_target : r_pc;
            w_state_nxt = (w_redir || !stall) ? REQ : VALID;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign imem_req     = (r_state == REQ);
   assign imem_addr    = r_pc;
   assign instr_valid  = (r_state == VALID);
   assign instr        = r_instr;
   assign instr_pc     = r_instr_pc;
   assign misalign_err = r_misalign;
endmodule

// File: tb/tb_pc_fetch_ctrl_rv32i.sv
// tb_pc_fetch_ctrl_rv32i: directed stimulus pushes expected fetch addresses and instructions into queues;
// a negedge monitor pops and compares whenever the DUT issues a granted request or presents a new instruction.
module tb_pc_fetch_ctrl_rv32i;
   logic        clock = 1'b0;
   logic        nreset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        misalign_err;

   int          n_chk = 0;
   int          n_fail = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] q_addr[$];
   logic [63:0] q_instr[$];

   pc_fetch_ctrl_rv32i #(.RESET_VECTOR(32'h00000000)) dut (
      .clock(clock), .nreset(nreset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .misalign_err(misalign_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // monitor: every granted request and every newly valid instruction must match the scoreboard head
   always @(negedge clock) begin
      if (imem_req && imem_gnt) begin
         if (q_addr.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL imem_addr_unexpected: got %h required no request", imem_addr);
         end else chk("imem_addr", {32'h0, imem_addr}, {32'h0, q_addr.pop_front()});
      end
      if (instr_valid && !prev_valid) begin
         if (q_instr.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL instr_unexpected: got pc %h instr %h required no instruction", instr_pc, instr);
         end else chk("instr_pc_instr", {instr_pc, instr}, q_instr.pop_front());
      end
      prev_valid = instr_valid;
   end

   task automatic wait_req(output bit ok);
      int n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      ok = imem_req;
      if (!ok) chk("req_timeout", 64'd0, 64'd1);
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int dly);
      bit ok;
      wait_req(ok);
      if (ok) begin
         q_addr.push_back(a);
         imem_gnt = 1'b1;
         tick();
         imem_gnt = 1'b0;
         repeat (dly) tick();
         q_instr.push_back({a, d});
         imem_rvalid = 1'b1;
         imem_rdata  = d;
         tick();
         imem_rvalid = 1'b0;
         chk("latency_valid", {63'd0, instr_valid}, 64'd1);
      end
   endtask

   initial begin
      bit ok;
      #2;
      chk("rst_req", {63'd0, imem_req}, 64'd0);
      chk("rst_valid", {63'd0, instr_valid}, 64'd0);
      chk("rst_instr", {instr_pc, instr}, 64'd0);
      chk("rst_addr", {32'h0, imem_addr}, 64'd0);
      chk("rst_mis", {63'd0, misalign_err}, 64'd0);
      tick();
      nreset = 1'b1;
      fetch(32'h0, 32'h00000013, 0);
      fetch(32'h4, 32'h00000013, 0);
      fetch(32'h8, 32'h00100093, 2);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", {63'd0, instr_valid}, 64'd1);
         chk("stall_pc", {32'h0, instr_pc}, 64'h8);
         chk("stall_req", {63'd0, imem_req}, 64'd0);
      end
      // redirect wins over stall
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFFFFFC;
      tick();
      redirect_valid = 1'b0;
      stall = 1'b0;
      chk("redir_drop_valid", {63'd0, instr_valid}, 64'd0);
      fetch(32'hFFFFFFFC, 32'h00200113, 0);
      fetch(32'h00000000, 32'h00000013, 1);
      // redirect while waiting; late response must be discarded
      wait_req(ok);
      q_addr.push_back(32'h4);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h00001000;
      tick();
      redirect_valid = 1'b0;
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEADBEEF;
      tick();
      imem_rvalid = 1'b0;
      chk("flush_valid", {63'd0, instr_valid}, 64'd0);
      chk("flush_instr", {instr_pc, instr}, {32'h0, 32'h00000013});
      chk("flush_addr", {32'h0, imem_addr}, 64'h1000);
      fetch(32'h00001000, 32'h00300193, 0);
      // misaligned redirect: one-cycle error pulse, nothing else changes
      stall = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h00001002;
      tick();
      redirect_valid = 1'b0;
      chk("mis_pulse", {63'd0, misalign_err}, 64'd1);
      chk("mis_hold_valid", {63'd0, instr_valid}, 64'd1);
      chk("mis_hold_addr", {32'h0, imem_addr}, 64'h1004);
      tick();
      chk("mis_clear", {63'd0, misalign_err}, 64'd0);
      stall = 1'b0;
      fetch(32'h00001004, 32'h00400213, 0);
      // asynchronous reset during WAIT
      wait_req(ok);
      q_addr.push_back(32'h1008);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      nreset = 1'b0;
      #1;
      chk("arst_req", {63'd0, imem_req}, 64'd0);
      chk("arst_valid", {63'd0, instr_valid}, 64'd0);
      chk("arst_instr", {instr_pc, instr}, 64'd0);
      chk("arst_addr", {32'h0, imem_addr}, 64'd0);
      chk("arst_mis", {63'd0, misalign_err}, 64'd0);
      tick();
      tick();
      nreset = 1'b1;
      chk("post_rst_req", {63'd0, imem_req}, 64'd0);
      fetch(32'h0, 32'h00000013, 0);
      tick();
      chk("q_addr_empty", 64'(q_addr.size()), 64'd0);
      chk("q_instr_empty", 64'(q_instr.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_fetch_ctrl_rv32i.md
PC_FETCH_CTRL_RV32I -- requirements
Module: pc_fetch_ctrl_rv32i

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, SHALL be the PC value loaded on reset (word-aligned).
REQ-002 Port list SHALL be exactly, one per line (name  direction  width  meaning):
- clock  input  1  single system clock; all state updates on rising edge.
- nreset  input  1  reset, asynchronous, active-low.
- stall  input  1  downstream not ready; holds the presented instruction.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC for redirect.
- imem_req  output  1  instruction-memory fetch request.
- imem_addr  output  32  fetch address (current PC).
- imem_gnt  input  1  memory accepted request this cycle.
- imem_rvalid  input  1  fetch data valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
- instr  output  32  fetched instruction.
- instr_pc  output  32  address of instr.
- misalign_err  output  1  one-cycle pulse: redirect target not word-aligned.

Function
REQ-003 Internal 32-bit pc register SHALL advance by exactly 4, modulo 2^32 (32'hFFFFFFFC + 4 = 32'h00000000, no carry out, no flag).
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, VALID; encoding free.
REQ-005 IDLE: all handshake outputs low; next state REQ unconditionally.
REQ-006 REQ: imem_req=1, imem_addr=pc (combinational from pc register); on imem_gnt=1 -> WAIT, else stay REQ with address stable.
REQ-007 WAIT: imem_req=0; on imem_rvalid=1 register instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, -> VALID.
REQ-008 VALID: instr_valid=1; stall=0 -> REQ next cycle (instruction consumed); stall=1 -> stay VALID, instr/instr_pc/pc unchanged.
REQ-009 instr_valid SHALL be 1 only in VALID; instr/instr_pc retain last value otherwise.
REQ-010 Latency: gnt in cycle N, rvalid in cycle N+k -> instr_valid high from cycle N+k+1; back-to-back throughput with zero-wait memory = one instruction per 3 cycles.
REQ-011 Redirect with redirect_target[1:0]==0 SHALL take priority over stall and normal increment: pc<=redirect_target.
REQ-012 Redirect in IDLE, REQ or VALID: instr_valid drops next cycle, next state REQ fetching redirect_target; a simultaneous imem_gnt in REQ is treated as accepted and the response discarded (state WAIT with flush set).
REQ-013 Redirect in WAIT without rvalid: set internal flush flag; stay WAIT; matching rvalid discarded (no instr update), flush cleared, -> REQ.
REQ-014 Redirect in WAIT coincident with rvalid: data discarded, -> REQ with pc=redirect_target.
REQ-015 Redirect with redirect_target[1:0]!=0: pc, state, flush unchanged; misalign_err=1 for that one following cycle only; redirect otherwise ignored.
REQ-016 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-017 nreset=0 SHALL asynchronously force: pc=RESET_VECTOR, state IDLE, flush=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, misalign_err=0.
REQ-018 Reset asserted mid-fetch SHALL abandon the outstanding request; first request after release issues to RESET_VECTOR on the second clock edge after release (IDLE->REQ).

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Reset release, gnt/rvalid immediate, rdata=32'h00000013 -> imem_addr 0,4,8 in successive fetches; instr_pc=0 with instr=32'h00000013.
- stall=1 for 5 cycles in VALID -> instr_valid stays 1, instr_pc unchanged, no imem_req.
- pc at 32'hFFFFFFFC, fetch completes -> next imem_addr=32'h00000000.
- redirect_target=32'h00001000 while in WAIT, rvalid 2 cycles later -> that data dropped (instr_valid stays 0), next imem_addr=32'h00001000.
- redirect_target=32'h00001002 -> misalign_err one-cycle pulse, pc sequence unaffected.
- nreset low during WAIT -> outputs zero immediately (before clock edge); after release first imem_addr=RESET_VECTOR.
